// File: rtl/rmt_cfg_pkg.sv
// Shared constants for the parse-action configuration path: control tag,
// header field offsets, action entry width and the FSM state encoding.
package rmt_cfg_pkg;

  localparam logic [15:0] RMT_CTRL_TAG      = 16'hF1F2;
  localparam int unsigned RMT_ACT_RAM_WIDTH = 260;

  localparam int unsigned TAG_LSB  = 128;
  localparam int unsigned ID_LSB   = 144;
  localparam int unsigned ADDR_LSB = 156;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FWD,
    ST_CFG1,
    ST_CFG2,
    ST_DROP,
    ST_GAP
  } state_t;

endpackage

// File: rtl/axis_reg_slice.sv
// Single-beat AXI-Stream output register; accepts a new beat whenever the
// held one is empty or being taken downstream in the same cycle.
module axis_reg_slice #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned USER_WIDTH = 128
) (
  input  logic                    axis_clk,
  input  logic                    aresetn,
  input  logic [DATA_WIDTH-1:0]   s_tdata,
  input  logic [USER_WIDTH-1:0]   s_tuser,
  input  logic [DATA_WIDTH/8-1:0] s_tkeep,
  input  logic                    s_tvalid,
  input  logic                    s_tlast,
  output logic                    s_tready,
  output logic [DATA_WIDTH-1:0]   m_tdata,
  output logic [USER_WIDTH-1:0]   m_tuser,
  output logic [DATA_WIDTH/8-1:0] m_tkeep,
  output logic                    m_tvalid,
  output logic                    m_tlast,
  input  logic                    m_tready
);

  assign s_tready = ~m_tvalid | m_tready;

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tuser  <= '0;
      m_tkeep  <= '0;
      m_tlast  <= 1'b0;
    end else if (s_tready) begin
      m_tvalid <= s_tvalid;
      if (s_tvalid) begin
        m_tdata <= s_tdata;
        m_tuser <= s_tuser;
        m_tkeep <= s_tkeep;
        m_tlast <= s_tlast;
      end
    end
  end

endmodule

// File: rtl/parse_act_cfg.sv
// Splits control packets (tag + module ID match) into parse-action RAM writes
// and forwards all other packets through a register slice with an idle gap.
module parse_act_cfg
  import rmt_cfg_pkg::*;
#(
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned ACT_RAM_WIDTH        = RMT_ACT_RAM_WIDTH,
  parameter int unsigned ACT_ADDR_WIDTH       = 4,
  parameter logic [15:0] CTRL_TAG             = RMT_CTRL_TAG,
  parameter logic [7:0]  MODULE_ID            = 8'h00,
  parameter int unsigned IPG_CYCLES           = 4
) (
  input  logic                                 axis_clk,
  input  logic                                 aresetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_tkeep,
  input  logic                                 s_axis_tvalid,
  input  logic                                 s_axis_tlast,
  output logic                                 s_axis_tready,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]     m_axis_tkeep,
  output logic                                 m_axis_tvalid,
  output logic                                 m_axis_tlast,
  input  logic                                 m_axis_tready,
  output logic [ACT_ADDR_WIDTH-1:0]            act_ram_addra,
  output logic [ACT_RAM_WIDTH-1:0]             act_ram_dina,
  output logic                                 act_ram_ena,
  output logic                                 act_ram_wea,
  output logic [15:0]                          cfg_wr_cnt,
  output logic [15:0]                          cfg_err_cnt
);

  state_t state, nxt;

  logic                           rst_done;
  logic                           slice_ready;
  logic                           fwd_valid;
  logic                           accept;
  logic                           is_ctrl;
  logic                           wr_pulse;
  logic [31:0]                    gap_cnt;
  logic [ACT_ADDR_WIDTH-1:0]      cfg_addr;
  logic [C_S_AXIS_DATA_WIDTH-1:0] entry_lo;

  assign is_ctrl = (s_axis_tdata[TAG_LSB +: 16] == CTRL_TAG) &&
                   (s_axis_tdata[ID_LSB +: 8] == MODULE_ID);
  assign accept  = s_axis_tvalid & s_axis_tready;

  assign act_ram_ena = wr_pulse;
  assign act_ram_wea = wr_pulse;

  // rst_done keeps tready low while reset is held and for the first edge after.
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= ST_IDLE;
      rst_done <= 1'b0;
    end else begin
      state    <= nxt;
      rst_done <= 1'b1;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE:
        if (accept) begin
          if (is_ctrl) nxt = s_axis_tlast ? ST_IDLE : ST_CFG1;
          else         nxt = s_axis_tlast ? ST_GAP  : ST_FWD;
        end
      ST_FWD:  if (accept && s_axis_tlast) nxt = ST_GAP;
      ST_CFG1: if (accept) nxt = s_axis_tlast ? ST_IDLE : ST_CFG2;
      ST_CFG2: if (accept) nxt = s_axis_tlast ? ST_IDLE : ST_DROP;
      ST_DROP: if (accept && s_axis_tlast) nxt = ST_IDLE;
      ST_GAP:  if (!m_axis_tvalid && (gap_cnt + 32'd1 >= IPG_CYCLES)) nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    s_axis_tready = 1'b0;
    fwd_valid     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        s_axis_tready = rst_done & slice_ready;
        fwd_valid     = s_axis_tvalid & s_axis_tready & ~is_ctrl;
      end
      ST_FWD: begin
        s_axis_tready = slice_ready;
        fwd_valid     = s_axis_tvalid & s_axis_tready;
      end
      ST_CFG1, ST_CFG2, ST_DROP: s_axis_tready = 1'b1;
      default: s_axis_tready = 1'b0;
    endcase
  end

  // Idle cycles are counted only once the final forwarded beat has left the slice.
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn)                gap_cnt <= '0;
    else if (state != ST_GAP)    gap_cnt <= '0;
    else if (!m_axis_tvalid)     gap_cnt <= gap_cnt + 32'd1;
  end

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      cfg_addr      <= '0;
      entry_lo      <= '0;
      wr_pulse      <= 1'b0;
      act_ram_addra <= '0;
      act_ram_dina  <= '0;
      cfg_wr_cnt    <= '0;
      cfg_err_cnt   <= '0;
    end else begin
      wr_pulse <= 1'b0;
      if (accept) begin
        unique case (state)
          ST_IDLE:
            if (is_ctrl) begin
              cfg_addr <= s_axis_tdata[ADDR_LSB +: ACT_ADDR_WIDTH];
              if (s_axis_tlast && cfg_err_cnt != '1) cfg_err_cnt <= cfg_err_cnt + 16'd1;
            end
          ST_CFG1: begin
            entry_lo <= s_axis_tdata;
            if (s_axis_tlast && cfg_err_cnt != '1) cfg_err_cnt <= cfg_err_cnt + 16'd1;
          end
          ST_CFG2: begin
            wr_pulse      <= 1'b1;
            act_ram_addra <= cfg_addr;
            act_ram_dina  <= {s_axis_tdata[ACT_RAM_WIDTH-C_S_AXIS_DATA_WIDTH-1:0], entry_lo};
            if (cfg_wr_cnt != '1) cfg_wr_cnt <= cfg_wr_cnt + 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

  axis_reg_slice #(
    .DATA_WIDTH (C_S_AXIS_DATA_WIDTH),
    .USER_WIDTH (C_S_AXIS_TUSER_WIDTH)
  ) u_out_slice (
    .axis_clk (axis_clk),
    .aresetn  (aresetn),
    .s_tdata  (s_axis_tdata),
    .s_tuser  (s_axis_tuser),
    .s_tkeep  (s_axis_tkeep),
    .s_tvalid (fwd_valid),
    .s_tlast  (s_axis_tlast),
    .s_tready (slice_ready),
    .m_tdata  (m_axis_tdata),
    .m_tuser  (m_axis_tuser),
    .m_tkeep  (m_axis_tkeep),
    .m_tvalid (m_axis_tvalid),
    .m_tlast  (m_axis_tlast),
    .m_tready (m_axis_tready)
  );

endmodule

// File: tb/tb_parse_act_cfg.sv
// Directed bench for parse_act_cfg: packet vector table plus hand sequences
// for backpressure/gap, write-pulse overlap and reset mid-packet.
module tb_parse_act_cfg;

  logic         axis_clk = 1'b0;
  logic         aresetn  = 1'b0;
  logic [255:0] s_axis_tdata  = '0;
  logic [127:0] s_axis_tuser  = '0;
  logic [31:0]  s_axis_tkeep  = '0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tlast  = 1'b0;
  logic         s_axis_tready;
  logic [255:0] m_axis_tdata;
  logic [127:0] m_axis_tuser;
  logic [31:0]  m_axis_tkeep;
  logic         m_axis_tvalid;
  logic         m_axis_tlast;
  logic         m_axis_tready = 1'b1;
  logic [3:0]   act_ram_addra;
  logic [259:0] act_ram_dina;
  logic         act_ram_ena;
  logic         act_ram_wea;
  logic [15:0]  cfg_wr_cnt;
  logic [15:0]  cfg_err_cnt;

  parse_act_cfg #(
    .IPG_CYCLES (4)
  ) dut (
    .axis_clk      (axis_clk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .act_ram_addra (act_ram_addra),
    .act_ram_dina  (act_ram_dina),
    .act_ram_ena   (act_ram_ena),
    .act_ram_wea   (act_ram_wea),
    .cfg_wr_cnt    (cfg_wr_cnt),
    .cfg_err_cnt   (cfg_err_cnt)
  );

  initial forever #5 axis_clk = ~axis_clk;

  typedef struct packed {
    logic [255:0] d;
    logic [127:0] u;
    logic [31:0]  k;
    logic         l;
  } beat_t;

  typedef struct {
    logic [15:0] tag;
    logic [7:0]  id;
    logic [3:0]  addr;
    logic [7:0]  fill;
    logic [3:0]  hi;
    int          nbeats;
    bit          exp_wr;
    bit          exp_err;
    bit          exp_fwd;
  } vec_t;

  int    n_applied = 0;
  int    n_miscompare = 0;
  int    cyc = 0;
  int    wea_cyc = -1;
  int    first_acc_cyc = -2;
  int    min_gap = 1000;
  int    gap_run = 0;
  bit    in_gap = 0;
  bit    toggle = 0;
  int    exp_wr = 0;
  int    exp_err = 0;
  beat_t tx[8];
  beat_t saved[8];
  beat_t rx_q[$];
  logic [3:0]   wr_addr_q[$];
  logic [259:0] wr_data_q[$];
  vec_t  vt[9];

  always @(posedge axis_clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge axis_clk);
    #1;
    if (toggle) m_axis_tready = ~m_axis_tready;
    else        m_axis_tready = 1'b1;
  end

  task automatic chk(input string nm, input logic [299:0] act, input logic [299:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miscompare++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge axis_clk) begin
    if (m_axis_tvalid) begin
      if (in_gap) begin
        if (gap_run < min_gap) min_gap = gap_run;
        in_gap = 0;
      end
      if (m_axis_tready) begin
        rx_q.push_back({m_axis_tdata, m_axis_tuser, m_axis_tkeep, m_axis_tlast});
        if (m_axis_tlast) begin
          in_gap  = 1;
          gap_run = 0;
        end
      end
    end else if (in_gap) begin
      gap_run++;
    end
    if (act_ram_wea) begin
      wr_addr_q.push_back(act_ram_addra);
      wr_data_q.push_back(act_ram_dina);
      wea_cyc = cyc;
      chk("ena_with_wea", 300'(act_ram_ena), 300'(1'b1));
    end
  end

  task automatic build(input logic [15:0] tag, input logic [7:0] id, input logic [3:0] addr,
                       input logic [7:0] fill, input logic [3:0] hi, input int n);
    logic [255:0] d;
    for (int b = 0; b < n; b++) begin
      d = {32{fill ^ 8'(b)}};
      if (b == 0) begin
        d[143:128] = tag;
        d[151:144] = id;
        d[159:156] = addr;
      end
      if (b == 1) d = {32{fill}};
      if (b == 2) begin
        d = {32{~fill}};
        d[3:0] = hi;
      end
      tx[b].d = d;
      tx[b].u = {112'h0, 8'(b), fill};
      tx[b].k = 32'hFFFF_FFFF ^ 32'(b);
      tx[b].l = (b == n - 1);
    end
  endtask

  task automatic send(input int n, input bit with_last);
    int waited;
    bit done;
    for (int b = 0; b < n; b++) begin
      s_axis_tdata  = tx[b].d;
      s_axis_tuser  = tx[b].u;
      s_axis_tkeep  = tx[b].k;
      s_axis_tlast  = with_last & tx[b].l;
      s_axis_tvalid = 1'b1;
      waited = 0;
      done   = 0;
      while (!done) begin
        @(negedge axis_clk);
        if (s_axis_tready) begin
          done = 1;
          if (b == 0) first_acc_cyc = cyc;
        end else if (waited > 300) begin
          n_applied++;
          n_miscompare++;
          $display("FAIL send_timeout: beat %0d not accepted, got tready=0 expected 1", b);
          done = 1;
        end
        waited++;
        @(posedge axis_clk);
        #1;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic settle();
    repeat (14) @(posedge axis_clk);
    #1;
  endtask

  task automatic clear_mon();
    rx_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic chk_beat(input string nm, input beat_t act, input beat_t exp);
    chk({nm, "_data"}, 300'(act.d), 300'(exp.d));
    chk({nm, "_side"}, 300'({act.u, act.k, act.l}), 300'({exp.u, exp.k, exp.l}));
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_m_tvalid"}, 300'(m_axis_tvalid), 300'(1'b0));
    chk({nm, "_s_tready"}, 300'(s_axis_tready), 300'(1'b0));
    chk({nm, "_ena_wea"},  300'({act_ram_ena, act_ram_wea}), 300'(2'b00));
    chk({nm, "_wr_cnt"},   300'(cfg_wr_cnt), 300'(16'h0));
    chk({nm, "_err_cnt"},  300'(cfg_err_cnt), 300'(16'h0));
    chk({nm, "_addra"},    300'(act_ram_addra), 300'(4'h0));
    chk({nm, "_dina"},     300'(act_ram_dina), 300'(260'h0));
  endtask

  initial begin
    vt[0] = '{16'hF1F2, 8'h00, 4'h5, 8'hA5, 4'hC, 3, 1'b1, 1'b0, 1'b0};
    vt[1] = '{16'hF1F2, 8'h00, 4'h2, 8'hB6, 4'h1, 2, 1'b0, 1'b1, 1'b0};
    vt[2] = '{16'hF1F2, 8'h00, 4'h3, 8'h3C, 4'h7, 3, 1'b1, 1'b0, 1'b0};
    vt[3] = '{16'hF1F2, 8'h01, 4'h4, 8'hC3, 4'h2, 3, 1'b0, 1'b0, 1'b1};
    vt[4] = '{16'h1234, 8'h00, 4'h5, 8'h10, 4'h0, 1, 1'b0, 1'b0, 1'b1};
    vt[5] = '{16'hF1F2, 8'h00, 4'hF, 8'hFF, 4'hF, 5, 1'b1, 1'b0, 1'b0};
    vt[6] = '{16'hF1F2, 8'h00, 4'h1, 8'h20, 4'h0, 1, 1'b0, 1'b1, 1'b0};
    vt[7] = '{16'hF1F2, 8'h02, 4'h8, 8'h44, 4'h0, 4, 1'b0, 1'b0, 1'b1};
    vt[8] = '{16'hF1F2, 8'h00, 4'h0, 8'h00, 4'h0, 3, 1'b1, 1'b0, 1'b0};

    repeat (3) @(posedge axis_clk);
    @(negedge axis_clk);
    chk_reset_outputs("por");
    @(posedge axis_clk);
    #1;
    aresetn = 1'b1;

    for (int i = 0; i < 9; i++) begin
      clear_mon();
      build(vt[i].tag, vt[i].id, vt[i].addr, vt[i].fill, vt[i].hi, vt[i].nbeats);
      send(vt[i].nbeats, 1'b1);
      settle();
      if (vt[i].exp_wr)  exp_wr++;
      if (vt[i].exp_err) exp_err++;
      chk($sformatf("v%0d_nwrites", i), 300'(wr_addr_q.size()), 300'(vt[i].exp_wr ? 1 : 0));
      if (vt[i].exp_wr && wr_addr_q.size() > 0) begin
        chk($sformatf("v%0d_addra", i), 300'(wr_addr_q[0]), 300'(vt[i].addr));
        chk($sformatf("v%0d_dina", i), 300'(wr_data_q[0]), 300'({vt[i].hi, {32{vt[i].fill}}}));
      end
      chk($sformatf("v%0d_wr_cnt", i), 300'(cfg_wr_cnt), 300'(exp_wr));
      chk($sformatf("v%0d_err_cnt", i), 300'(cfg_err_cnt), 300'(exp_err));
      chk($sformatf("v%0d_nbeats_out", i), 300'(rx_q.size()), 300'(vt[i].exp_fwd ? vt[i].nbeats : 0));
      for (int j = 0; j < rx_q.size() && j < vt[i].nbeats; j++)
        chk_beat($sformatf("v%0d_beat%0d", i, j), rx_q[j], tx[j]);
    end

    // Back-to-back data packets under alternating downstream ready.
    clear_mon();
    min_gap = 1000;
    in_gap  = 0;
    toggle  = 1;
    build(16'h0102, 8'h00, 4'h1, 8'h11, 4'h0, 2);
    saved[0] = tx[0];
    saved[1] = tx[1];
    send(2, 1'b1);
    build(16'h0304, 8'h00, 4'h2, 8'h22, 4'h0, 2);
    send(2, 1'b1);
    settle();
    toggle = 0;
    settle();
    chk("b2b_nbeats_out", 300'(rx_q.size()), 300'(4));
    if (rx_q.size() == 4) begin
      chk_beat("b2b_p0b0", rx_q[0], saved[0]);
      chk_beat("b2b_p0b1", rx_q[1], saved[1]);
      chk_beat("b2b_p1b0", rx_q[2], tx[0]);
      chk_beat("b2b_p1b1", rx_q[3], tx[1]);
    end
    chk("b2b_gap_ge4", 300'(min_gap >= 4 && min_gap < 1000), 300'(1'b1));
    chk("b2b_nwrites", 300'(wr_addr_q.size()), 300'(0));

    // Write pulse lands in the same cycle the next packet's first beat is taken.
    clear_mon();
    build(16'hF1F2, 8'h00, 4'h9, 8'h5A, 4'h3, 3);
    send(3, 1'b1);
    build(16'h0000, 8'h00, 4'h0, 8'h66, 4'h0, 1);
    send(1, 1'b1);
    settle();
    exp_wr++;
    chk("ovl_nwrites", 300'(wr_addr_q.size()), 300'(1));
    if (wr_addr_q.size() > 0) begin
      chk("ovl_addra", 300'(wr_addr_q[0]), 300'(4'h9));
      chk("ovl_dina", 300'(wr_data_q[0]), 300'({4'h3, {32{8'h5A}}}));
    end
    chk("ovl_same_cycle", 300'(wea_cyc), 300'(first_acc_cyc));
    chk("ovl_wr_cnt", 300'(cfg_wr_cnt), 300'(exp_wr));
    chk("ovl_nbeats_out", 300'(rx_q.size()), 300'(1));
    if (rx_q.size() > 0) chk_beat("ovl_beat", rx_q[0], tx[0]);

    // Reset while waiting for the final control beat.
    clear_mon();
    build(16'hF1F2, 8'h00, 4'h6, 8'h77, 4'h1, 3);
    send(2, 1'b0);
    aresetn = 1'b0;
    @(negedge axis_clk);
    chk_reset_outputs("rst_cfg2");
    repeat (2) @(posedge axis_clk);
    #1;
    aresetn = 1'b1;
    exp_wr  = 0;
    exp_err = 0;
    tx[0] = tx[2];
    tx[0].l = 1'b1;
    send(1, 1'b1);
    settle();
    chk("rst_leftover_nwrites", 300'(wr_addr_q.size()), 300'(0));
    chk("rst_leftover_nbeats_out", 300'(rx_q.size()), 300'(1));
    if (rx_q.size() > 0) chk_beat("rst_leftover_beat", rx_q[0], tx[0]);
    clear_mon();
    build(16'hF1F2, 8'h00, 4'h6, 8'h77, 4'h1, 3);
    send(3, 1'b1);
    settle();
    exp_wr++;
    chk("rst_recover_nwrites", 300'(wr_addr_q.size()), 300'(1));
    if (wr_addr_q.size() > 0) begin
      chk("rst_recover_addra", 300'(wr_addr_q[0]), 300'(4'h6));
      chk("rst_recover_dina", 300'(wr_data_q[0]), 300'({4'h1, {32{8'h77}}}));
    end
    chk("rst_recover_wr_cnt", 300'(cfg_wr_cnt), 300'(exp_wr));
    chk("rst_recover_err_cnt", 300'(cfg_err_cnt), 300'(exp_err));
    chk("rst_recover_nbeats_out", 300'(rx_q.size()), 300'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompare);
    $finish;
  end

endmodule

// File: doc/parse_act_cfg.md
PARSE_ACT_CFG -- requirements
Module: parse_act_cfg

Interface
REQ-001 Parameters (name, default, meaning):
- C_S_AXIS_DATA_WIDTH, 256, stream data width.
- C_S_AXIS_TUSER_WIDTH, 128, stream user width.
- ACT_RAM_WIDTH, 260, parse action entry width.
- ACT_ADDR_WIDTH, 4, parse action RAM address width.
- CTRL_TAG, 16'hF1F2, control-packet tag value.
- MODULE_ID, 8'h00, this parser's ID.
- IPG_CYCLES, 4, minimum idle cycles after each forwarded tlast.
REQ-002 Ports (name, direction, width, meaning):
- axis_clk, in, 1, clock.
- aresetn, in, 1, asynchronous active-low reset.
- s_axis_tdata/tuser/tkeep/tvalid/tlast, in, 256/128/32/1/1, upstream packets.
- s_axis_tready, out, 1, upstream ready.
- m_axis_tdata/tuser/tkeep/tvalid/tlast, out, 256/128/32/1/1, data packets to parser.
- m_axis_tready, in, 1, downstream ready.
- act_ram_addra, out, 4, RAM write address.
- act_ram_dina, out, 260, RAM write data.
- act_ram_ena, out, 1, RAM port enable.
- act_ram_wea, out, 1, RAM write enable.
- cfg_wr_cnt, out, 16, completed entry writes.
- cfg_err_cnt, out, 16, aborted control packets.
REQ-003 Reset is aresetn, asynchronous, active-low; clock is axis_clk.

Function
REQ-004 The block SHALL classify a packet on its first accepted beat: control iff tdata[143:128]==CTRL_TAG and tdata[151:144]==MODULE_ID; otherwise data.
REQ-005 The FSM SHALL have the states IDLE, FWD, CFG1, CFG2, DROP and GAP.
REQ-006 IDLE: a data first beat goes to FWD, or to GAP if tlast; a control first beat latches addr=tdata[159:156] and goes to CFG1, or to IDLE with cfg_err_cnt+1 if tlast.
REQ-007 CFG1: an accepted beat SHALL latch entry[255:0]=tdata; tlast SHALL abort to IDLE with cfg_err_cnt+1, otherwise go to CFG2.
REQ-008 CFG2: an accepted beat SHALL form entry[259:256]=tdata[3:0].
REQ-009 CFG2 write: on the next cycle, act_ram_ena=act_ram_wea=1 for exactly one cycle with addra=addr and dina=entry, and cfg_wr_cnt increments.
REQ-010 CFG2 exit: next state is IDLE if that beat had tlast, else DROP.
REQ-011 DROP SHALL accept and discard beats until tlast, then return to IDLE; no write, no counter change.
REQ-012 Control packets SHALL never appear on m_axis; s_axis_tready=1 in CFG1, CFG2 and DROP.
REQ-013 Data beats SHALL pass through a single output register with 1-cycle latency and tdata/tuser/tkeep/tlast unmodified.
REQ-014 In IDLE and FWD, s_axis_tready = ~m_axis_tvalid | m_axis_tready; no beat is lost or duplicated under backpressure.
REQ-015 FWD SHALL go to GAP when a tlast beat is accepted.
REQ-016 GAP SHALL hold s_axis_tready=0 until the last forwarded beat has drained; m_axis_tvalid then stays 0 for IPG_CYCLES cycles before returning to IDLE.
REQ-017 cfg_wr_cnt and cfg_err_cnt SHALL saturate at 16'hFFFF.
REQ-018 If a write pulse and a new first beat coincide, both SHALL complete, with no stall.

Reset
REQ-019 On reset, state=IDLE; m_axis_tvalid, s_axis_tready, act_ram_ena, act_ram_wea, the counters, addra and dina SHALL all be 0.
REQ-020 Reset during any state SHALL abandon the packet without a RAM write; the remaining beats after release are treated as a new packet.

Structure
REQ-021 CTRL_TAG, the field bit offsets, the FSM state encoding and ACT_RAM_WIDTH SHALL live in a shared package, rmt_cfg_pkg.
REQ-022 The output register SHALL be a sub-module, axis_reg_slice, holding one beat.

Verification
REQ-023 3-beat control packet, tag F1F2, ID 00, addr 5, beat1=all A5, beat2[3:0]=C -> one wea pulse, addra=5, dina={4'hC, {32{8'hA5}}}, cfg_wr_cnt=1, m_axis silent.
REQ-024 2-beat control packet with tlast on beat1 -> no wea, cfg_err_cnt=1, next packet is processed normally.
REQ-025 Control packet with ID 01 -> forwarded as data unchanged, no write.
REQ-026 Back-to-back 2-beat data packets with m_axis_tready toggling 1010… -> both delivered intact, ≥4 idle cycles between them.
REQ-027 aresetn asserted in CFG2 before the beat is accepted -> no wea, all outputs 0, recovery on the next packet.
